imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Boot-time loader sitting upstream of the CPU top: accepts a byte stream
//   (valid/ready), assembles little-endian 32-bit words, writes them into
//   instruction memory from word 0 upward, verifies an XOR checksum, then
//   releases the CPU via cpu_run. Replaces file-based imem preload and the
//   bench-driven start pulse on hardware.
// PARAMETERS
//   ADDR_W   8    instruction memory word-address width (capacity 2**ADDR_W words)
//   DATA_W   32   memory word width; fixed at 32, 4 bytes per word
// PORTS
//   clk           in   1       system clock, all logic on rising edge
//   rst           in   1       synchronous, active-high reset
//   s_valid       in   1       input byte valid
//   s_ready       out  1       loader can accept a byte this cycle
//   s_data        in   8       input byte
//   mem_we        out  1       instruction memory write enable (1-cycle pulse)
//   mem_addr      out  ADDR_W  word address of write
//   mem_wdata     out  32      word to write
//   cpu_run       out  1       1 = CPU released (drive CPU reset inactive)
//   busy          out  1       1 = load in progress (LEN_LO..CSUM after first byte)
//   err           out  1       1 = load failed (sticky until rst)
//   words_loaded  out  ADDR_W+1  count of words written so far
// BEHAVIOUR
//   Frame: LEN_LO, LEN_HI (16-bit word count N, LE), 4*N payload bytes (LE per
//   word), CSUM byte = XOR of every preceding byte of the frame incl. length.
//   Byte accepted only when s_valid & s_ready in the same cycle.
//   Reset values: s_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0,
//   busy=0, err=0, words_loaded=0; state=LEN_LO, byte lane=0, xor acc=0.
//   States and transitions:
//   - LEN_LO: accept -> len[7:0], acc^=byte, busy=1 -> LEN_HI.
//   - LEN_HI: accept -> len[15:8]; if len > 2**ADDR_W -> ERROR;
//     elif len==0 -> CSUM; else -> DATA.
//   - DATA: each accept shifts byte into lane 0..3, acc^=byte; on lane 3
//     accept: next cycle mem_we=1, mem_addr=word index, mem_wdata={b3,b2,b1,b0},
//     words_loaded incremented in same cycle as mem_we; after word N-1 -> CSUM.
//   - CSUM: accept; byte==acc -> DONE else -> ERROR.
//   - DONE: s_ready=0, busy=0, cpu_run=1 from cycle after CSUM accept; terminal.
//   - ERROR: s_ready=0, busy=0, err=1, cpu_run=0; terminal.
//   s_ready is 1 in LEN_LO/LEN_HI/DATA/CSUM, 0 in DONE/ERROR; combinational
//   from state only (never from s_valid).
//   Write latency: exactly 1 cycle after 4th byte handshake; back-to-back words
//   at 1 byte/cycle never overlap (min 4 cycles between mem_we pulses).
//   Boundaries: len==2**ADDR_W accepted (last addr = all ones, words_loaded =
//   2**ADDR_W, no wrap); len==2**ADDR_W+1 -> ERROR, no memory write.
//   s_valid gaps anywhere: state, lane and acc hold.
//   rst mid-load: all regs to reset values next edge; already-written memory
//   words untouched; cpu_run stays 0 until a full new frame passes.
//   Bytes presented in DONE/ERROR are not consumed (s_ready=0).
// TESTING
//   1) N=1, bytes 01 00 13 00 00 00 csum=12 -> mem_we once, addr 0,
//      wdata 0x00000013, cpu_run=1 next cycle after csum, err=0.
//   2) N=2 with s_valid toggled every other cycle -> two writes addr 0,1,
//      words_loaded=2, data identical to gap-free run.
//   3) N=1 with csum=FF (wrong) -> one write occurs, then err=1, cpu_run=0,
//      s_ready=0 held for 20 cycles.
//   4) N=0, bytes 00 00 csum=00 -> no mem_we, cpu_run=1, words_loaded=0.
//   5) ADDR_W=8, N=256 -> last write addr 0xFF, words_loaded=256, DONE;
//      N=257 -> ERROR right after LEN_HI, no mem_we ever.
//   6) rst asserted after 3rd payload byte, then full valid frame -> clean
//      reload from addr 0, cpu_run=1 only after second frame's csum.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed byte frame,
// writes little-endian words from address 0, checks an XOR checksum, then releases the CPU.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    // state    | meaning
    // LEN_LO   | idle, waiting for low byte of word count
    // LEN_HI   | waiting for high byte of word count
    // DATA     | collecting payload bytes, one word per 4 bytes
    // CSUM     | waiting for checksum byte
    // DONE     | frame verified, CPU released (terminal)
    // ERROR    | bad length or checksum (terminal until rst)
    localparam logic [2:0] S_LEN_LO = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CSUM   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

    logic [2:0]      state;
    logic [15:0]     len;
    logic [1:0]      lane;
    logic [7:0]      acc;
    logic [23:0]     shift;
    logic            accept;
    logic [15:0]     len_next;
    logic [ADDR_W:0] wl_next;

    assign s_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CSUM);
    assign busy     = (state == S_LEN_HI) || (state == S_DATA) || (state == S_CSUM);
    assign cpu_run  = (state == S_DONE);
    assign err      = (state == S_ERROR);
    assign accept   = s_valid && s_ready;
    assign len_next = {s_data, len[7:0]};
    assign wl_next  = words_loaded + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_LEN_LO;
            len          <= '0;
            lane         <= '0;
            acc          <= '0;
            shift        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                acc <= acc ^ s_data;
                case (state)
                    S_LEN_LO: begin
                        len[7:0] <= s_data;
                        state    <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        len <= len_next;
                        if ({1'b0, len_next} > MAX_LEN)
                            state <= S_ERROR;
                        else if (len_next == 16'd0)
                            state <= S_CSUM;
                        else
                            state <= S_DATA;
                    end
                    S_DATA: begin
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            // Word assembled from the three buffered bytes plus this one.
                            mem_we       <= 1'b1;
                            mem_addr     <= words_loaded[ADDR_W-1:0];
                            mem_wdata    <= {s_data, shift};
                            words_loaded <= wl_next;
                            if (17'(wl_next) == {1'b0, len})
                                state <= S_CSUM;
                        end else begin
                            shift <= {s_data, shift[23:8]};
                        end
                    end
                    S_CSUM: begin
                        if (s_data == acc)
                            state <= S_DONE;
                        else
                            state <= S_ERROR;
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven and random frames checked against a byte-level
// model of the frame format (expected words and checksum computed from the byte list).
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_run(cpu_run),
        .busy(busy), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // write monitor: counts pulses, checks sequential addresses and pulse spacing
    int wr_count = 0;
    int addr_bad = 0;
    int spacing_bad = 0;
    int cyc = 0;
    int last_we = -100;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            wr_count = 0;
            addr_bad = 0;
            spacing_bad = 0;
            last_we = -100;
        end else if (mem_we) begin
            if (int'(mem_addr) != (wr_count % (2 ** ADDR_W))) addr_bad = addr_bad + 1;
            if (cyc - last_we < 4) spacing_bad = spacing_bad + 1;
            last_we = cyc;
            wr_count = wr_count + 1;
        end
    end

    typedef struct {
        int n;
        bit corrupt;
        int gap;
        bit exp_run;
        bit exp_err;
        int exp_words;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] frame_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_words", {23'd0, words_loaded}, 32'd0);
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
        x = 8'h00;
        foreach (frame_q[i]) x = x ^ frame_q[i];
        b = corrupt ? (x ^ 8'h5A) : x;
        frame_q.push_back(b);
    endtask

    // Entered and left at a negedge; checks each completed word the cycle after its 4th byte.
    task automatic send_frame(input int max_bytes, input int gap);
        int n;
        int p;
        int w;
        logic rdy;
        logic [31:0] exp_word;
        n = int'({frame_q[1], frame_q[0]});
        for (int i = 0; i < frame_q.size() && i < max_bytes; i++) begin
            if (i > 0 && gap == 1) begin
                s_valid = 1'b0;
                s_data = 8'($urandom);
                @(negedge clk);
            end else if (i > 0 && gap == 2) begin
                for (int k = $urandom_range(0, 2); k > 0; k--) begin
                    s_valid = 1'b0;
                    s_data = 8'($urandom);
                    @(negedge clk);
                end
            end
            s_valid = 1'b1;
            s_data = frame_q[i];
            rdy = s_ready;
            @(posedge clk);
            @(negedge clk);
            if (!rdy) break;
            if (i == 0) chk("busy_after_len_lo", {31'd0, busy}, 32'd1);
            p = i - 2;
            if (p >= 0 && p < 4 * n && (p % 4) == 3) begin
                w = p / 4;
                exp_word = {frame_q[i], frame_q[i-1], frame_q[i-2], frame_q[i-3]};
                chk("word_we", {31'd0, mem_we}, 32'd1);
                chk("word_addr", {24'd0, mem_addr}, 32'(w % (2 ** ADDR_W)));
                chk("word_data", mem_wdata, exp_word);
                chk("word_count", {23'd0, words_loaded}, 32'(w + 1));
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic check_end(input bit exp_run, input bit exp_err, input int exp_words);
        chk("end_cpu_run", {31'd0, cpu_run}, {31'd0, exp_run});
        chk("end_err", {31'd0, err}, {31'd0, exp_err});
        chk("end_words", {23'd0, words_loaded}, 32'(exp_words));
        chk("end_wr_count", 32'(wr_count), 32'(exp_words));
        chk("end_s_ready", {31'd0, s_ready}, 32'd0);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("end_addr_seq", 32'(addr_bad), 32'd0);
        chk("end_spacing", 32'(spacing_bad), 32'd0);
    endtask

    initial begin
        int n;
        bit cor;
        bit ok;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;

        vecs.push_back('{n: 2,   corrupt: 1'b0, gap: 1, exp_run: 1'b1, exp_err: 1'b0, exp_words: 2});
        vecs.push_back('{n: 2,   corrupt: 1'b0, gap: 0, exp_run: 1'b1, exp_err: 1'b0, exp_words: 2});
        vecs.push_back('{n: 0,   corrupt: 1'b0, gap: 0, exp_run: 1'b1, exp_err: 1'b0, exp_words: 0});
        vecs.push_back('{n: 256, corrupt: 1'b0, gap: 0, exp_run: 1'b1, exp_err: 1'b0, exp_words: 256});
        vecs.push_back('{n: 257, corrupt: 1'b0, gap: 0, exp_run: 1'b0, exp_err: 1'b1, exp_words: 0});
        vecs.push_back('{n: 3,   corrupt: 1'b0, gap: 2, exp_run: 1'b1, exp_err: 1'b0, exp_words: 3});
        vecs.push_back('{n: 5,   corrupt: 1'b1, gap: 2, exp_run: 1'b0, exp_err: 1'b1, exp_words: 5});
        vecs.push_back('{n: 0,   corrupt: 1'b1, gap: 1, exp_run: 1'b0, exp_err: 1'b1, exp_words: 0});

        // single word, fixed bytes, csum 0x12
        do_reset();
        frame_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        send_frame(100, 0);
        chk("t1_wdata", mem_wdata, 32'h0000_0013);
        check_end(1'b1, 1'b0, 1);

        // wrong checksum: word still written, then terminal error with bytes refused
        do_reset();
        frame_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hFF};
        send_frame(100, 0);
        check_end(1'b0, 1'b1, 1);
        for (int k = 0; k < 20; k++) begin
            s_valid = 1'b1;
            s_data = 8'($urandom);
            @(negedge clk);
            chk("hold_err", {29'd0, err, cpu_run, s_ready}, 32'h4);
        end
        s_valid = 1'b0;
        chk("hold_wr_count", 32'(wr_count), 32'd1);

        // table-driven frames with random payload
        foreach (vecs[v]) begin
            do_reset();
            build_frame(vecs[v].n, vecs[v].corrupt);
            send_frame(100000, vecs[v].gap);
            check_end(vecs[v].exp_run, vecs[v].exp_err, vecs[v].exp_words);
        end

        // reset in the middle of a load, then a full frame
        do_reset();
        build_frame(2, 1'b0);
        send_frame(5, 0);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_cpu_run", {31'd0, cpu_run}, 32'd0);
        do_reset();
        build_frame(3, 1'b0);
        send_frame(100000, 2);
        check_end(1'b1, 1'b0, 3);

        // random frames against the model
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(0, 12);
            if ($urandom_range(0, 7) == 0) n = $urandom_range(250, 260);
            cor = ($urandom_range(0, 3) == 0);
            ok = !cor && (n <= 2 ** ADDR_W);
            do_reset();
            build_frame(n, cor);
            send_frame(100000, $urandom_range(0, 2));
            check_end(ok, !ok, (n <= 2 ** ADDR_W) ? n : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
